// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared N:1 serial bit mux, registered out/valid.
// Ports: clk, rst (sync, active-high); req/in per-lane request and data bit;
// grant one-hot owner, select owner index, out/valid registered muxed bit, busy in GRANT.
// Macro HOLD_LIMIT_EN caps each tenure at MAX_HOLD grant cycles.
module mux_rr_arbiter #(
  parameter int sel      = 3,
  parameter int IN       = 2**sel,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IN-1:0] req,
  input  logic [IN-1:0] in,
  output logic [IN-1:0] grant,
  output logic [sel-1:0] select,
  output logic          valid,
  output logic          out,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state_q;
  logic [IN-1:0] grant_q;
  logic [sel-1:0] select_q, ptr_q, win;
  logic out_q, valid_q, stay;
  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
    $error("MAX_HOLD out of range 2..256");
  end
`ifdef HOLD_LIMIT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q;
  assign stay = req[select_q] && (hold_q != HW'(MAX_HOLD - 1));
`else
  assign stay = req[select_q];
`endif
  // downward scan so the lane closest to ptr (offset 0) is assigned last and wins
  always_comb begin
    win = ptr_q;
    for (int i = IN - 1; i >= 0; i--) if (req[ptr_q + sel'(i)]) win = ptr_q + sel'(i);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      select_q <= '0;
      ptr_q    <= '0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef HOLD_LIMIT_EN
      hold_q   <= '0;
`endif
    end else begin
      out_q   <= (state_q == GRANT) ? in[select_q] : 1'b0;
      valid_q <= state_q == GRANT;
      case (state_q)
        GRANT: begin
          if (stay) begin
`ifdef HOLD_LIMIT_EN
            hold_q <= hold_q + 1'b1;
`endif
          end else begin
            state_q <= RELEASE;
            grant_q <= '0;
            ptr_q   <= select_q + 1'b1;
          end
        end
        default: begin
          if (|req) begin
            state_q  <= GRANT;
            grant_q  <= IN'(1) << win;
            select_q <= win;
`ifdef HOLD_LIMIT_EN
            hold_q   <= '0;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign grant  = grant_q;
  assign select = select_q;
  assign valid  = valid_q;
  assign out    = out_q;
  assign busy   = state_q == GRANT;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed and random checks of mux_rr_arbiter against a behavioural owner model.
module tb_mux_rr_arbiter;
  localparam int SEL = 3;
  localparam int IN = 8;
  localparam int MH = 4;
`ifdef HOLD_LIMIT_EN
  localparam int LIMIT = MH;
`else
  localparam int LIMIT = 1 << 30;
`endif
  logic clk = 0, rst = 1;
  logic [IN-1:0] req = '0, in = '0, grant;
  logic [SEL-1:0] select;
  logic valid, out, busy;
  int errors = 0, checks = 0;
  int m_owner = -1, m_sel = 0, m_ptr = 0, m_ten = 0;
  logic m_out = 0, m_valid = 0;
  mux_rr_arbiter #(.sel(SEL), .IN(IN), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .in(in), .grant(grant),
    .select(select), .valid(valid), .out(out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: one owner at a time; after a tenure ends there is one ownerless cycle,
  // and the next owner is the first requester found walking up from the lane after the last owner.
  always @(posedge clk) begin
    logic [IN-1:0] eg;
    if (rst) begin
      m_owner = -1; m_sel = 0; m_ptr = 0; m_ten = 0; m_out = 0; m_valid = 0;
    end else begin
      m_valid = m_owner >= 0;
      m_out = (m_owner >= 0) ? in[m_owner] : 1'b0;
      if (m_owner >= 0) begin
        if (req[m_owner] && m_ten < LIMIT) m_ten++;
        else begin
          m_ptr = (m_owner + 1) % IN;
          m_owner = -1;
        end
      end else if (req != 0) begin
        for (int k = IN - 1; k >= 0; k--) if (req[(m_ptr + k) % IN]) m_owner = (m_ptr + k) % IN;
        m_sel = m_owner;
        m_ten = 1;
      end
    end
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("grant", grant, eg);
    chk("select", select, m_sel);
    chk("busy", busy, m_owner >= 0);
    chk("valid", valid, m_valid);
    chk("out", out, m_out);
  end
  task automatic do_reset();
    @(negedge clk); rst = 1; req = '0; in = '0;
    @(negedge clk); rst = 0;
  endtask
  task automatic tenure(output int lane);
    lane = -1;
    for (int c = 0; c < 40 && lane < 0; c++) begin
      @(posedge clk); #1;
      if (grant != 0) lane = select;
    end
    if (lane < 0) begin
      checks++; errors++;
      $display("FAIL grant_timeout: got no grant within 40 cycles, required a grant");
    end else begin
      repeat (2) @(posedge clk);
      @(negedge clk); req[lane] = 1'b0;
      @(negedge clk); req[lane] = 1'b1;
    end
  endtask
  initial begin
    int l;
    logic [4:0] seq;
    logic [IN-1:0] e;
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int l;
    logic [4:0] seq;
    logic [IN-1:0] e;
    do_reset();
    @(posedge clk); #1;
    chk("rst_grant", grant, 0);
    chk("rst_select", select, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    seq = 5'b01101;
    @(negedge clk); req = 8'h04;
    @(posedge clk); #1;
    chk("single_grant", grant, 8'h04);
    chk("single_select", select, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); in[2] = seq[k];
      @(posedge clk); #1;
      chk("single_out", out, seq[k]);
      chk("single_valid", valid, 1);
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    chk("midrst_grant", grant, 0);
    chk("midrst_select", select, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_out", out, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk); rst = 0; req = '0; in = '0;
    do_reset();
    @(negedge clk); req = '1;
    for (int t = 0; t < 9; t++) begin
      tenure(l);
      chk("rr_order", l, t % IN);
    end
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk); req = 8'h40;
    tenure(l);
    chk("wrap_setup", l, 6);
    req = 8'h81;
    tenure(l); chk("wrap_first", l, 7);
    tenure(l); chk("wrap_second", l, 0);
    tenure(l); chk("wrap_third", l, 7);
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk); req = 8'h08;
    @(posedge clk); #1; chk("edge_owner", grant, 8'h08);
    @(negedge clk); req = 8'h20;
    @(posedge clk); #1; chk("edge_gap", grant, 0); chk("edge_gap_busy", busy, 0);
    @(posedge clk); #1; chk("edge_grant", grant, 8'h20); chk("edge_select", select, 5);
    @(negedge clk); req = '0;
    repeat (3) @(negedge clk);
    do_reset();
    @(negedge clk); req = 8'h03;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
`ifdef HOLD_LIMIT_EN
      e = (c <= 4 || c == 11) ? 8'h01 : (c == 5 || c == 10) ? 8'h00 : 8'h02;
`else
      e = 8'h01;
`endif
      chk("hold_trace", grant, e);
    end
    @(negedge clk); req = '0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom % 200) == 0;
      for (int b = 0; b < IN; b++) if ($urandom % 8 == 0) req[b] = ~req[b];
      in = IN'($urandom);
    end
    @(negedge clk); rst = 0; req = '0;
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
